// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types and helpers for the APB memory bus arbiter.
//               - arb_state_t : sequencing states (IDLE/SETUP/ACCESS/RESP)
//               - gnt_t       : requester identity (fetch / data)
//               - apb_strb_w  : APB byte-strobe width for a data width
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  function automatic int apb_strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. A lone request wins outright;
//               on a tie the requester that did not win last time is chosen.
// Ports       : req[1:0]   - request vector, bit 0 = fetch, bit 1 = data
//               last_grant - requester served by the previous transfer
//               gnt_valid  - at least one request present
//               gnt_id     - chosen requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last_grant,
  output logic       gnt_valid,
  output gnt_t       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_FETCH;
    case (req)
      2'b01:   gnt_id = GNT_FETCH;
      2'b10:   gnt_id = GNT_DATA;
      2'b11:   gnt_id = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
      default: gnt_id = GNT_FETCH;
    endcase
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one APB master port between the instruction-fetch
//               and load/store requesters. Arbitrates round-robin, runs the
//               APB SETUP/ACCESS sequence with a timeout watchdog and returns
//               registered read data with a one-cycle ready pulse.
// Ports       : clk, rst                      - clock, sync active-high reset
//               if_req/if_addr                - fetch request (level)
//               if_rdata/if_ready/if_err      - fetch completion
//               d_req/d_we/d_addr/d_wdata/d_strb - data request (level)
//               d_rdata/d_ready/d_err         - data completion
//               psel/penable/pwrite/paddr/pwdata/pstrb - APB master outputs
//               prdata/pready/pslverr         - APB slave responses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_err,
  // load/store requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_err,
  // APB master
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = apb_strb_w(DATA_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  gnt_t                r_last_grant;
  gnt_t                r_gnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;

  logic                w_gnt_valid;
  gnt_t                w_gnt_id;
  logic                w_grant_load;
  logic                w_done;
  logic                w_timeout;
  logic                w_complete;
  logic [DATA_W-1:0]   w_rdata_cap;
  logic                w_err_cap;

  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ready;
  logic                r_d_ready;
  logic                r_if_err;
  logic                r_d_err;

  // Fetches are always word aligned, so the two address LSBs are dropped.
  logic                w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^if_addr[1:0];

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, if_req}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_load = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_grant_load = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // w_cnt_inc is the number of ACCESS cycles including this one.
        if (pready) begin
          w_done       = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_cnt_inc == c_timeout) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // No arbitration here: a requester still holding req is picked up
        // in the following IDLE cycle.
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_complete  = w_done | w_timeout;
  // Write responses and errored/aborted reads return zero data.
  assign w_rdata_cap = (w_timeout | pslverr | r_pwrite) ? {DATA_W{1'b0}} : prdata;
  assign w_err_cap   = w_timeout | pslverr;

  // --------------------------------------------------------------------------
  // Transfer datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_FETCH;
      r_gnt        <= GNT_FETCH;
      r_cnt        <= {CNT_W{1'b0}};
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= {ADDR_W{1'b0}};
      r_pwdata     <= {DATA_W{1'b0}};
      r_pstrb      <= {STRB_W{1'b0}};
      r_if_rdata   <= {DATA_W{1'b0}};
      r_d_rdata    <= {DATA_W{1'b0}};
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
      r_if_err     <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      // Ready and error are single-cycle pulses aligned with RESP.
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_err    <= 1'b0;

      if (w_grant_load) begin
        r_gnt     <= w_gnt_id;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_cnt     <= {CNT_W{1'b0}};
        if (w_gnt_id == GNT_DATA) begin
          r_pwrite <= d_we;
          r_paddr  <= d_addr;
          r_pwdata <= d_wdata;
          r_pstrb  <= d_we ? d_strb : {STRB_W{1'b0}};
        end else begin
          r_pwrite <= 1'b0;
          r_paddr  <= {if_addr[ADDR_W-1:2], 2'b00};
          r_pwdata <= {DATA_W{1'b0}};
          r_pstrb  <= {STRB_W{1'b0}};
        end
      end

      if (r_state == ST_SETUP) begin
        r_penable <= 1'b1;
      end

      if (r_state == ST_ACCESS) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_complete) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
        if (r_gnt == GNT_DATA) begin
          r_d_rdata <= w_rdata_cap;
          r_d_err   <= w_err_cap;
          r_d_ready <= 1'b1;
        end else begin
          r_if_rdata <= w_rdata_cap;
          r_if_err   <= w_err_cap;
          r_if_ready <= 1'b1;
        end
      end

      if (r_state == ST_RESP) begin
        r_last_grant <= r_gnt;
      end
    end
  end

  assign psel     = r_psel;
  assign penable  = r_penable;
  assign pwrite   = r_pwrite;
  assign paddr    = r_paddr;
  assign pwdata   = r_pwdata;
  assign pstrb    = r_pstrb;
  assign if_rdata = r_if_rdata;
  assign if_ready = r_if_ready;
  assign if_err   = r_if_err;
  assign d_rdata  = r_d_rdata;
  assign d_ready  = r_d_ready;
  assign d_err    = r_d_err;

endmodule : mem_bus_arbiter
`default_nettype wire
